// File: rtl/jamma_pkg.sv
`default_nettype none
// ============================================================================
// jamma_pkg : shared channel/event widths and event-code helper
// Rev 1.0
// ============================================================================
package jamma_pkg;

    localparam int CH_NUM = 16;
    localparam int CH_W   = 4;
    localparam int EVT_W  = 5;

    typedef logic [EVT_W-1:0] evt_t;

    // Event code layout: {new level, channel index}
    function automatic evt_t make_evt(input logic level, input logic [CH_W-1:0] ch);
        return {level, ch};
    endfunction

endpackage
`default_nettype wire

// File: rtl/jamma_evt_fifo.sv
`default_nettype none
// ============================================================================
// jamma_evt_fifo : power-of-two event queue with registered storage/head
// Rev 1.0
// ============================================================================
module jamma_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full queue still takes a push when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/jamma_input_scanner.sv
`default_nettype none
// ============================================================================
// jamma_input_scanner : one-channel-per-tick JAMMA switch debouncer with
//                       change-event FIFO and sticky overflow flag
// Rev 1.0
// ============================================================================
module jamma_input_scanner
    import jamma_pkg::*;
#(
    parameter int DEB_TH     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [CH_NUM-1:0] raw,
    output logic [CH_W-1:0]   scan_sel,
    output logic [CH_NUM-1:0] state,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [EVT_W-1:0]  evt_code,
    output logic              overflow,
    input  logic              ovf_clr
);

    logic [3:0] cnt [CH_NUM];
    logic       sample;
    logic       cur;
    logic [4:0] cnt_inc;
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;
    evt_t       new_evt;

    assign sample  = raw[scan_sel];
    assign cur     = state[scan_sel];
    assign cnt_inc = {1'b0, cnt[scan_sel]} + 5'd1;
    assign accept  = tick && (sample != cur) && (cnt_inc == 5'(DEB_TH));
    assign new_evt = make_evt(sample, scan_sel);
    // Full implies non-empty, so evt_ready alone tells whether the head pops
    assign drop    = accept && fifo_full && !evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_sel <= '0;
            state    <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                cnt[i] <= '0;
            end
        end else if (tick) begin
            scan_sel <= scan_sel + 1'b1;
            if (sample == cur) begin
                cnt[scan_sel] <= '0;
            end else if (accept) begin
                state[scan_sel] <= ~cur;
                cnt[scan_sel]   <= '0;
            end else begin
                cnt[scan_sel] <= cnt_inc[3:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    jamma_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (new_evt),
        .pop       (evt_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (evt_code)
    );

    assign evt_valid = !fifo_empty;

endmodule
`default_nettype wire

// File: doc/jamma_input_scanner.md
JAMMA_INPUT_SCANNER -- requirements
Module: jamma_input_scanner

Interface
REQ-001 SHALL have parameter DEB_TH, default 3: consecutive differing samples needed to accept a channel change (range 1..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port tick  input  1: scan-step enable; one channel is sampled per cycle with tick=1.
REQ-006 SHALL have port raw  input  16: raw JAMMA switch levels, channel k = raw[k].
REQ-007 SHALL have port scan_sel  output  4: index of the channel sampled at the next tick.
REQ-008 SHALL have port state  output  16: debounced level per channel.
REQ-009 SHALL have port evt_valid  output  1: the FIFO head holds an event.
REQ-010 SHALL have port evt_ready  input  1: consumer accepts the head event.
REQ-011 SHALL have port evt_code  output  5: {new level, channel[3:0]} of the head event.
REQ-012 SHALL have port overflow  output  1: sticky flag; an event was lost.
REQ-013 SHALL have port ovf_clr  input  1: synchronous clear of overflow.

Function
REQ-014 SHALL sample channel scan_sel on each tick=1 cycle, then advance scan_sel by 1, wrapping 15->0; scan_sel SHALL hold while tick=0.
REQ-015 SHALL keep a 4-bit debounce count per channel.
REQ-016 SHALL, when raw[i]==state[i] at the sample, clear cnt[i].
REQ-017 SHALL, when raw[i]!=state[i] and cnt[i]+1<DEB_TH, increment cnt[i].
REQ-018 SHALL, when raw[i]!=state[i] and cnt[i]+1==DEB_TH, toggle state[i], clear cnt[i], and request push of {raw[i], i}.
REQ-019 SHALL update state[i] on the same edge as the sample (1-cycle latency from the tick edge to state).
REQ-020 SHALL present a pushed event at evt_valid/evt_code on the cycle after the push edge if the FIFO was empty.
REQ-021 SHALL pop the head on a rising edge with evt_valid=1 and evt_ready=1; evt_code SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-022 SHALL accept a push when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-023 SHALL discard a push when full and no pop, and set overflow; state[i] SHALL still toggle.
REQ-024 SHALL give a simultaneous overflow set and ovf_clr priority to the set.
REQ-025 SHALL preserve FIFO order (first in, first out); at most one push per cycle by construction.
REQ-026 SHALL ignore evt_ready while evt_valid=0; a pop on empty SHALL NOT happen.

Reset
REQ-027 SHALL, on reset=1, asynchronously set scan_sel=0, state=16'h0000, all cnt=0, FIFO empty (evt_valid=0, evt_code=0), overflow=0.
REQ-028 SHALL discard any in-flight debounce progress and queued events on reset mid-operation; scanning resumes at channel 0 on the first tick after release.

Structure
REQ-029 SHALL take CH_NUM=16, CH_W=4 and EVT_W=5 from a shared package jamma_pkg.
REQ-030 SHALL place the event queue in a sub-module jamma_evt_fifo: parameterised depth, push/pop, full/empty, and the registered head.
REQ-031 SHALL keep scan index, debounce counters and state registers in the top module.

Verification
REQ-032 Reset mid-scan: scan_sel=9 with cnt[9]=2, assert reset -> scan_sel=0, state=0, evt_valid=0, overflow=0 immediately.
REQ-033 Debounce accept: tick=1 continuously, raw[5]=1 held, DEB_TH=3 -> state[5]=1 after the third visit to channel 5 (cycle 3*16-11=37 from release), evt_code=5'h15.
REQ-034 Glitch reject: raw[2]=1 for two visits then 0, DEB_TH=3 -> state[2] stays 0, no event.
REQ-035 Back-pressure: evt_ready=0, toggle raw[0..4] -> four events queued in order (codes 10,11,12,13), fifth lost, overflow=1; state[4]=1.
REQ-036 Full with pop: FIFO full, evt_ready=1 on the same edge as a push -> push accepted, overflow stays 0, count stays 4.
REQ-037 Release and wrap: tick every 3rd cycle -> scan_sel holds between ticks, wraps 15->0; raw[15] 1->0 after acceptance -> evt_code=5'h0F.
